// File: rtl/mips_core_pkg.sv
// mips_core_pkg: types and constants shared by the branch-speculation snapshot logic.
//   snap_state_t   : snapshot_controller sequencing states
//   NUM_REGS       : architectural register count (r0 hard-wired, never tracked)
//   REG_ADDR_WIDTH : register address width
package mips_core_pkg;

   localparam int unsigned NUM_REGS       = 32;
   localparam int unsigned REG_ADDR_WIDTH = 5;

   typedef enum logic [2:0] {
      StIdle,
      StCaptWait,
      StArmed,
      StRestore,
      StDone
   } snap_state_t;

endpackage

// File: rtl/dirty_first_set.sv
// dirty_first_set: combinational lowest-set-bit encoder.
//   mask  : input bit vector
//   index : position of the lowest set bit (0 when mask is empty)
//   valid : mask has at least one bit set
module dirty_first_set #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IDX_W = 5
) (
   input  logic [WIDTH-1:0] mask,
   output logic [IDX_W-1:0] index,
   output logic             valid
);

   always_comb begin
      index = '0;
      // Scan downwards so the lowest set bit is the last one to win.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            index = IDX_W'(i);
         end
      end
   end

   assign valid = |mask;

endmodule

// File: rtl/snapshot_controller.sv
// snapshot_controller: checkpoint/restore sequencer for branch speculation.
// Captures a register-file checkpoint when a predicted branch issues, and on a
// mispredict replays checkpointed values through the register-file write port,
// one register per cycle, while holding the pipeline stalled.
//
// Build option SNAPSHOT_DIRTY_SKIP_EN: when defined, registers overwritten while
// speculative are tracked and only those are restored; otherwise r1..r31 are
// all rewritten on every rollback.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   take_req/ready   : checkpoint request / accepted only in idle
//   release_req      : branch resolved correctly, drop checkpoint
//   rollback_req     : mispredict, restore checkpoint (wins over release)
//   wb_valid/addr    : write-back commit seen this cycle
//   snap_capture     : one-cycle pulse, storage samples the register file
//   snap_regs        : checkpointed values from the storage
//   rf_we/waddr/wdata: restore write port into the register file
//   stall            : freeze fetch/issue during capture and restore
//   restore_done     : one-cycle pulse at the end of a restore
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module snapshot_controller #(
   parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
   parameter int unsigned NUM_REGS   = 32
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     take_req,
   output logic                                     take_ready,
   input  logic                                     release_req,
   input  logic                                     rollback_req,
   input  logic                                     wb_valid,
   input  logic [mips_core_pkg::REG_ADDR_WIDTH-1:0] wb_addr,
   output logic                                     snap_capture,
   input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]      snap_regs,
   output logic                                     rf_we,
   output logic [mips_core_pkg::REG_ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0]                    rf_wdata,
   output logic                                     stall,
   output logic                                     restore_done
);

   import mips_core_pkg::*;

   localparam logic [NUM_REGS-1:0] OneHot0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

   snap_state_t                state_q;
   // Registers still to be restored; while armed it doubles as the dirty set.
   logic [NUM_REGS-1:0]        mask_q;
   logic [NUM_REGS-1:0]        enc_in;
   logic [NUM_REGS-1:0]        first_bit;
   logic [REG_ADDR_WIDTH-1:0]  first_idx;
   logic                       first_valid;

`ifdef SNAPSHOT_DIRTY_SKIP_EN
   logic [NUM_REGS-1:0] wb_bit;

   assign wb_bit = (wb_valid && wb_addr != '0) ? (OneHot0 << wb_addr) : '0;
   // A rollback also sees a write-back committing in the same cycle.
   assign enc_in = (state_q == StArmed) ? (mask_q | wb_bit) : mask_q;
`else
   localparam logic [NUM_REGS-1:0] AllRegs = {{(NUM_REGS-1){1'b1}}, 1'b0};

   logic unused_wb;

   assign unused_wb = ^{wb_valid, wb_addr};
   assign enc_in    = (state_q == StArmed) ? AllRegs : mask_q;
`endif

   dirty_first_set #(
      .WIDTH (NUM_REGS),
      .IDX_W (REG_ADDR_WIDTH)
   ) u_first_set (
      .mask  (enc_in),
      .index (first_idx),
      .valid (first_valid)
   );

   assign first_bit  = OneHot0 << first_idx;
   assign take_ready = (state_q == StIdle);
   assign rf_wdata   = snap_regs[rf_waddr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         mask_q       <= '0;
         snap_capture <= 1'b0;
         stall        <= 1'b0;
         rf_we        <= 1'b0;
         rf_waddr     <= '0;
         restore_done <= 1'b0;
      end else begin
         snap_capture <= 1'b0;
         stall        <= 1'b0;
         rf_we        <= 1'b0;
         rf_waddr     <= '0;
         restore_done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // One idle cycle lets the in-flight write-back land before capture.
               if (take_req) begin
                  state_q      <= StCaptWait;
                  snap_capture <= 1'b1;
                  stall        <= 1'b1;
               end
            end
            StCaptWait: begin
               mask_q  <= '0;
               state_q <= (rollback_req || release_req) ? StIdle : StArmed;
            end
            StArmed: begin
               if (rollback_req) begin
                  stall <= 1'b1;
                  if (first_valid) begin
                     state_q  <= StRestore;
                     rf_we    <= 1'b1;
                     rf_waddr <= first_idx;
                     mask_q   <= enc_in & ~first_bit;
                  end else begin
                     state_q      <= StDone;
                     restore_done <= 1'b1;
                     mask_q       <= '0;
                  end
               end else if (release_req) begin
                  state_q <= StIdle;
                  mask_q  <= '0;
               end else begin
`ifdef SNAPSHOT_DIRTY_SKIP_EN
                  mask_q <= enc_in;
`endif
               end
            end
            StRestore: begin
               stall <= 1'b1;
               if (first_valid) begin
                  rf_we    <= 1'b1;
                  rf_waddr <= first_idx;
                  mask_q   <= mask_q & ~first_bit;
               end else begin
                  state_q      <= StDone;
                  restore_done <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Write-back must be frozen while the register file is being restored.
   assert property (@(posedge clk) disable iff (!rst_n)
      !(wb_valid && (state_q == StRestore || state_q == StDone)));

endmodule

// File: tb/tb_snapshot_controller.sv
module tb_snapshot_controller;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 32;

   logic                   clk;
   logic                   rst_n;
   logic                   take_req;
   logic                   take_ready;
   logic                   release_req;
   logic                   rollback_req;
   logic                   wb_valid;
   logic [4:0]             wb_addr;
   logic                   snap_capture;
   logic [NR-1:0][DW-1:0]  snap_regs;
   logic                   rf_we;
   logic [4:0]             rf_waddr;
   logic [DW-1:0]          rf_wdata;
   logic                   stall;
   logic                   restore_done;

   int tests;
   int failed;

   // Reference model: set of registers overwritten while speculative, and the
   // ordered list of registers a rollback must rewrite.
   bit exp_dirty [NR];
   int exp_list [$];

   snapshot_controller #(
      .DATA_WIDTH (DW),
      .NUM_REGS   (NR)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .take_req     (take_req),
      .take_ready   (take_ready),
      .release_req  (release_req),
      .rollback_req (rollback_req),
      .wb_valid     (wb_valid),
      .wb_addr      (wb_addr),
      .snap_capture (snap_capture),
      .snap_regs    (snap_regs),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .stall        (stall),
      .restore_done (restore_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, tests=%0d failed=%0d", tests, failed);
      $fatal(1, "watchdog expired");
   end

   task automatic drive(input logic tk, input logic rl, input logic rb, input logic wv,
                        input logic [4:0] wa);
      take_req     = tk;
      release_req  = rl;
      rollback_req = rb;
      wb_valid     = wv;
      wb_addr      = wa;
   endtask

   // Advance to just after the next rising edge and return inputs to idle.
   task automatic step();
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   task automatic fill_snap();
      for (int r = 0; r < NR; r++) snap_regs[r] = $urandom;
   endtask

   function automatic void clear_dirty();
      for (int r = 0; r < NR; r++) exp_dirty[r] = 1'b0;
   endfunction

   function automatic void build_list();
      exp_list.delete();
      for (int r = 1; r < NR; r++) begin
`ifdef SNAPSHOT_DIRTY_SKIP_EN
         if (exp_dirty[r]) exp_list.push_back(r);
`else
         exp_list.push_back(r);
`endif
      end
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      fill_snap();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (take_ready !== 1'b1) begin
         failed++; $display("FAIL reset_take_ready: got %0b want 1", take_ready);
      end
      tests++;
      if (stall !== 1'b0 || rf_we !== 1'b0) begin
         failed++; $display("FAIL reset_stall_we: got stall=%0b we=%0b want 0 0", stall, rf_we);
      end
      tests++;
      if (snap_capture !== 1'b0 || restore_done !== 1'b0) begin
         failed++;
         $display("FAIL reset_pulses: got capture=%0b done=%0b want 0 0", snap_capture,
                  restore_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      tests++;
      if (take_ready !== 1'b1 || stall !== 1'b0) begin
         failed++;
         $display("FAIL post_reset_idle: got ready=%0b stall=%0b want 1 0", take_ready, stall);
      end
   endtask

   task automatic test_rollback();
      int         n_arm;
      logic       wv;
      logic [4:0] wa;
      for (int it = 0; it < 6; it++) begin
         fill_snap();
         clear_dirty();
         tests++;
         if (take_ready !== 1'b1) begin
            failed++; $display("FAIL rb_take_ready it=%0d: got %0b want 1", it, take_ready);
         end
         drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
         step();
         tests++;
         if (snap_capture !== 1'b1 || stall !== 1'b1 || take_ready !== 1'b0) begin
            failed++;
            $display("FAIL rb_capture it=%0d: got capture=%0b stall=%0b ready=%0b want 1 1 0",
                     it, snap_capture, stall, take_ready);
         end
         // A write-back here belongs to the snapshot, so the model ignores it.
         drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
         step();
         tests++;
         if (snap_capture !== 1'b0 || stall !== 1'b0) begin
            failed++;
            $display("FAIL rb_armed_entry it=%0d: got capture=%0b stall=%0b want 0 0", it,
                     snap_capture, stall);
         end
         if (it == 0) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
            exp_dirty[3] = 1'b1;
            step();
            drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
            exp_dirty[9] = 1'b1;
            step();
         end else begin
            n_arm = $urandom_range(1, 8);
            for (int k = 0; k < n_arm; k++) begin
               wv = 1'($urandom_range(0, 1));
               wa = 5'($urandom_range(0, 31));
               drive(1'b0, 1'b0, 1'b0, wv, wa);
               if (wv && wa != 5'd0) exp_dirty[wa] = 1'b1;
               step();
               tests++;
               if (stall !== 1'b0 || rf_we !== 1'b0 || restore_done !== 1'b0) begin
                  failed++;
                  $display("FAIL rb_armed it=%0d: got stall=%0b we=%0b done=%0b want 0 0 0",
                           it, stall, rf_we, restore_done);
               end
            end
         end
         build_list();
         // Odd iterations also raise release: rollback has priority.
         drive(1'b0, 1'(it % 2), 1'b1, 1'b0, 5'd0);
         for (int j = 0; j < exp_list.size(); j++) begin
            step();
            tests++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(exp_list[j]) ||
                rf_wdata !== snap_regs[exp_list[j]] || stall !== 1'b1 || restore_done !== 1'b0)
            begin
               failed++;
               $display("FAIL rb_write it=%0d j=%0d: got we=%0b addr=%0d data=%h stall=%0b done=%0b want 1 %0d %h 1 0",
                        it, j, rf_we, rf_waddr, rf_wdata, stall, restore_done, exp_list[j],
                        snap_regs[exp_list[j]]);
            end
         end
         step();
         tests++;
         if (restore_done !== 1'b1 || rf_we !== 1'b0 || stall !== 1'b1) begin
            failed++;
            $display("FAIL rb_done it=%0d: got done=%0b we=%0b stall=%0b want 1 0 1", it,
                     restore_done, rf_we, stall);
         end
         step();
         tests++;
         if (take_ready !== 1'b1 || stall !== 1'b0 || restore_done !== 1'b0) begin
            failed++;
            $display("FAIL rb_idle it=%0d: got ready=%0b stall=%0b done=%0b want 1 0 0", it,
                     take_ready, stall, restore_done);
         end
      end
   endtask

   task automatic test_release();
      int n_arm;
      for (int it = 0; it < 3; it++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
         step();
         step();
         n_arm = $urandom_range(1, 4);
         for (int k = 0; k < n_arm; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, (k == 0) ? 5'd5 : 5'($urandom_range(1, 31)));
            step();
         end
         drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
         step();
         tests++;
         if (take_ready !== 1'b1 || stall !== 1'b0 || rf_we !== 1'b0) begin
            failed++;
            $display("FAIL rel_idle it=%0d: got ready=%0b stall=%0b we=%0b want 1 0 0", it,
                     take_ready, stall, rf_we);
         end
         // A rollback with nothing armed must be ignored.
         drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
         for (int k = 0; k < 2; k++) begin
            step();
            tests++;
            if (rf_we !== 1'b0 || restore_done !== 1'b0 || stall !== 1'b0) begin
               failed++;
               $display("FAIL rel_quiet it=%0d k=%0d: got we=%0b done=%0b stall=%0b want 0 0 0",
                        it, k, rf_we, restore_done, stall);
            end
         end
      end
   endtask

   task automatic test_r0_only();
      fill_snap();
      clear_dirty();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      step();
      step();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
         step();
      end
      build_list();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
      for (int j = 0; j < exp_list.size(); j++) begin
         step();
         tests++;
         if (rf_we !== 1'b1 || rf_waddr !== 5'(exp_list[j]) || rf_wdata !== snap_regs[exp_list[j]])
         begin
            failed++;
            $display("FAIL r0_write j=%0d: got we=%0b addr=%0d data=%h want 1 %0d %h", j, rf_we,
                     rf_waddr, rf_wdata, exp_list[j], snap_regs[exp_list[j]]);
         end
      end
      step();
      tests++;
      if (restore_done !== 1'b1 || rf_we !== 1'b0 || stall !== 1'b1) begin
         failed++;
         $display("FAIL r0_done: got done=%0b we=%0b stall=%0b want 1 0 1", restore_done, rf_we,
                  stall);
      end
      step();
   endtask

   task automatic test_captwait();
      fill_snap();
      clear_dirty();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      step();
      // Write-back of r7 lands in the snapshot; the repeated take is ignored.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd7);
      step();
      tests++;
      if (snap_capture !== 1'b0 || take_ready !== 1'b0 || stall !== 1'b0) begin
         failed++;
         $display("FAIL cw_ignore_take: got capture=%0b ready=%0b stall=%0b want 0 0 0",
                  snap_capture, take_ready, stall);
      end
      build_list();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
      for (int j = 0; j < exp_list.size(); j++) begin
         step();
         tests++;
         if (rf_we !== 1'b1 || rf_waddr !== 5'(exp_list[j]) || rf_wdata !== snap_regs[exp_list[j]])
         begin
            failed++;
            $display("FAIL cw_write j=%0d: got we=%0b addr=%0d data=%h want 1 %0d %h", j, rf_we,
                     rf_waddr, rf_wdata, exp_list[j], snap_regs[exp_list[j]]);
         end
      end
      step();
      tests++;
      if (restore_done !== 1'b1 || rf_we !== 1'b0) begin
         failed++;
         $display("FAIL cw_done: got done=%0b we=%0b want 1 0", restore_done, rf_we);
      end
      step();
      // Cancel during capture with each request in turn.
      for (int c = 0; c < 2; c++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
         step();
         tests++;
         if (snap_capture !== 1'b1 || stall !== 1'b1) begin
            failed++;
            $display("FAIL cancel_capture c=%0d: got capture=%0b stall=%0b want 1 1", c,
                     snap_capture, stall);
         end
         drive(1'b0, 1'(c == 0), 1'(c == 1), 1'b0, 5'd0);
         step();
         tests++;
         if (take_ready !== 1'b1 || stall !== 1'b0 || snap_capture !== 1'b0) begin
            failed++;
            $display("FAIL cancel_idle c=%0d: got ready=%0b stall=%0b capture=%0b want 1 0 0", c,
                     take_ready, stall, snap_capture);
         end
         step();
         tests++;
         if (rf_we !== 1'b0 || restore_done !== 1'b0 || stall !== 1'b0) begin
            failed++;
            $display("FAIL cancel_quiet c=%0d: got we=%0b done=%0b stall=%0b want 0 0 0", c,
                     rf_we, restore_done, stall);
         end
      end
   endtask

   task automatic test_reset_mid_restore();
      int a;
      int b;
      int c;
      fill_snap();
      clear_dirty();
      a = $urandom_range(1, 10);
      b = a + $urandom_range(1, 10);
      c = b + $urandom_range(1, 10);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      step();
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 5'(c));
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 5'(a));
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 5'(b));
      step();
      exp_dirty[a] = 1'b1;
      exp_dirty[b] = 1'b1;
      exp_dirty[c] = 1'b1;
      build_list();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
      step();
      tests++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(exp_list[0])) begin
         failed++;
         $display("FAIL mid_first_write: got we=%0b addr=%0d want 1 %0d", rf_we, rf_waddr,
                  exp_list[0]);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (rf_we !== 1'b0 || stall !== 1'b0 || take_ready !== 1'b1 || restore_done !== 1'b0) begin
         failed++;
         $display("FAIL mid_reset: got we=%0b stall=%0b ready=%0b done=%0b want 0 0 1 0", rf_we,
                  stall, take_ready, restore_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         tests++;
         if (rf_we !== 1'b0 || stall !== 1'b0 || restore_done !== 1'b0 || take_ready !== 1'b1)
         begin
            failed++;
            $display("FAIL post_reset_rollback k=%0d: got we=%0b stall=%0b done=%0b ready=%0b want 0 0 0 1",
                     k, rf_we, stall, restore_done, take_ready);
         end
      end
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      test_reset();
      test_rollback();
      test_release();
      test_r0_only();
      test_captwait();
      test_reset_mid_restore();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
